// File: rtl/apb2iob_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb2iob_if
//  Description : Bus bundle for the APB-slave / IOb-master bridge. The slave
//                modport is the bridge's view; the master modport is the view
//                of the environment (APB master plus IOb slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb2iob_if #(
    parameter int APB_ADDR_W = 32,
    parameter int ADDR_W     = APB_ADDR_W,
    parameter int DATA_W     = 32
);
    // APB side
    logic                  apb_sel_i;
    logic                  apb_enable_i;
    logic [APB_ADDR_W-1:0] apb_addr_i;
    logic                  apb_write_i;
    logic [DATA_W/8-1:0]   apb_wstrb_i;
    logic [DATA_W-1:0]     apb_wdata_i;
    logic [DATA_W-1:0]     apb_rdata_o;
    logic                  apb_ready_o;
    logic                  apb_slverr_o;
    // IOb side
    logic                  iob_avalid_o;
    logic [ADDR_W-1:0]     iob_addr_o;
    logic [DATA_W-1:0]     iob_wdata_o;
    logic [DATA_W/8-1:0]   iob_wstrb_o;
    logic                  iob_rvalid_i;
    logic [DATA_W-1:0]     iob_rdata_i;
    logic                  iob_ready_i;

    modport slave (
        input  apb_sel_i, apb_enable_i, apb_addr_i, apb_write_i, apb_wstrb_i, apb_wdata_i,
        output apb_rdata_o, apb_ready_o, apb_slverr_o,
        output iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o,
        input  iob_rvalid_i, iob_rdata_i, iob_ready_i
    );

    modport master (
        output apb_sel_i, apb_enable_i, apb_addr_i, apb_write_i, apb_wstrb_i, apb_wdata_i,
        input  apb_rdata_o, apb_ready_o, apb_slverr_o,
        input  iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o,
        output iob_rvalid_i, iob_rdata_i, iob_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/apb2iob.sv
`default_nettype none
// ============================================================================
//  Module      : apb2iob
//  Description : APB slave to IOb master bridge. Each APB transfer becomes a
//                single IOb request; an optional cycle timeout turns an
//                unresponsive IOb slave into an APB slave error.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb2iob #(
    parameter int APB_ADDR_W = 32,
    parameter int APB_DATA_W = 32,
    parameter int ADDR_W     = APB_ADDR_W,
    parameter int DATA_W     = APB_DATA_W,
    parameter int TIMEOUT    = 256
) (
    input  wire logic clk_i,
    input  wire logic arst_n_i,
    input  wire logic cke_i,
    apb2iob_if.slave  bus
);

    // A zero-width counter is illegal, so keep one bit when the timeout is off.
    localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit c_TO_EN = (TIMEOUT > 0);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_RDWAIT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state, w_state;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt;
    logic                r_avalid, w_avalid;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic [DATA_W-1:0]   r_wdata, w_wdata;
    logic [DATA_W/8-1:0] r_wstrb, w_wstrb;
    logic [DATA_W-1:0]   r_rdata, w_rdata;
    logic                r_ready, w_ready;
    logic                r_slverr, w_slverr;

    logic w_setup;
    logic w_null_wr;
    logic w_timeout;

    assign w_setup   = bus.apb_sel_i && !bus.apb_enable_i && !r_ready;
    assign w_null_wr = bus.apb_write_i && (bus.apb_wstrb_i == '0);
    assign w_timeout = c_TO_EN && (r_cnt == c_CNT_LAST);

    // State and all registered outputs; cke_i low freezes everything.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_avalid <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_rdata  <= '0;
            r_ready  <= 1'b0;
            r_slverr <= 1'b0;
        end else if (cke_i) begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_avalid <= w_avalid;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_wstrb  <= w_wstrb;
            r_rdata  <= w_rdata;
            r_ready  <= w_ready;
            r_slverr <= w_slverr;
        end
    end

    // Next-state and next-output logic; a completing event beats the timeout.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_avalid = r_avalid;
        w_addr   = r_addr;
        w_wdata  = r_wdata;
        w_wstrb  = r_wstrb;
        w_rdata  = r_rdata;
        w_ready  = r_ready;
        w_slverr = r_slverr;
        case (r_state)
            S_IDLE: begin
                if (w_setup) begin
                    w_addr  = bus.apb_addr_i[ADDR_W-1:0];
                    w_wdata = bus.apb_wdata_i;
                    w_wstrb = bus.apb_write_i ? bus.apb_wstrb_i : '0;
                    if (w_null_wr) begin
                        w_ready  = 1'b1;
                        w_slverr = 1'b0;
                        w_state  = S_DONE;
                    end else begin
                        w_avalid = 1'b1;
                        w_cnt    = '0;
                        w_state  = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.iob_ready_i) begin
                    w_avalid = 1'b0;
                    w_cnt    = r_cnt + c_CNT_ONE;
                    // Reads always carry a zero strobe, so a non-zero one marks a write.
                    if (r_wstrb != '0) begin
                        w_ready = 1'b1;
                        w_state = S_DONE;
                    end else begin
                        w_state = S_RDWAIT;
                    end
                end else if (w_timeout) begin
                    w_avalid = 1'b0;
                    w_rdata  = '0;
                    w_slverr = 1'b1;
                    w_ready  = 1'b1;
                    w_state  = S_DONE;
                end else begin
                    w_cnt = r_cnt + c_CNT_ONE;
                end
            end
            S_RDWAIT: begin
                if (bus.iob_rvalid_i) begin
                    w_rdata = bus.iob_rdata_i;
                    w_ready = 1'b1;
                    w_state = S_DONE;
                end else if (w_timeout) begin
                    w_rdata  = '0;
                    w_slverr = 1'b1;
                    w_ready  = 1'b1;
                    w_state  = S_DONE;
                end else begin
                    w_cnt = r_cnt + c_CNT_ONE;
                end
            end
            S_DONE: begin
                w_ready  = 1'b0;
                w_slverr = 1'b0;
                w_wstrb  = '0;
                w_state  = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.apb_rdata_o  = r_rdata;
    assign bus.apb_ready_o  = r_ready;
    assign bus.apb_slverr_o = r_slverr;
    assign bus.iob_avalid_o = r_avalid;
    assign bus.iob_addr_o   = r_addr;
    assign bus.iob_wdata_o  = r_wdata;
    assign bus.iob_wstrb_o  = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_apb2iob.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb2iob
//  Description : Directed self-checking bench for the apb2iob bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb2iob;

    logic clk = 1'b0;
    logic arst_n;
    logic cke;

    apb2iob_if #(.APB_ADDR_W(32), .ADDR_W(32), .DATA_W(32)) bus ();

    apb2iob #(
        .APB_ADDR_W (32),
        .APB_DATA_W (32),
        .ADDR_W     (32),
        .DATA_W     (32),
        .TIMEOUT    (8)
    ) dut (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .cke_i    (cke),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Mid-cycle monitor: accepted IOb requests and cycles with avalid high
    logic [31:0] acc_addr[$];
    int          n_av_cycles = 0;
    always @(negedge clk) begin
        if (bus.iob_avalid_o) n_av_cycles++;
        if (bus.iob_avalid_o && bus.iob_ready_i) acc_addr.push_back(bus.iob_addr_o);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle and settle just after the active edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
        bus.apb_sel_i    = 1'b1;
        bus.apb_enable_i = 1'b0;
        bus.apb_write_i  = wr;
        bus.apb_addr_i   = addr;
        bus.apb_wdata_i  = data;
        bus.apb_wstrb_i  = strb;
    endtask

    task automatic idle_bus();
        bus.apb_sel_i    = 1'b0;
        bus.apb_enable_i = 1'b0;
    endtask

    int av0;

    initial begin
        arst_n = 1'b0;
        cke    = 1'b1;
        bus.apb_sel_i    = 1'b0;
        bus.apb_enable_i = 1'b0;
        bus.apb_addr_i   = '0;
        bus.apb_write_i  = 1'b0;
        bus.apb_wstrb_i  = '0;
        bus.apb_wdata_i  = '0;
        bus.iob_rvalid_i = 1'b0;
        bus.iob_rdata_i  = '0;
        bus.iob_ready_i  = 1'b0;
        step();
        step();
        check("rst_avalid", 32'(bus.iob_avalid_o), 32'd0);
        check("rst_ready",  32'(bus.apb_ready_o),  32'd0);
        check("rst_slverr", 32'(bus.apb_slverr_o), 32'd0);
        check("rst_rdata",  bus.apb_rdata_o,       32'd0);
        check("rst_wstrb",  32'(bus.iob_wstrb_o),  32'd0);
        arst_n = 1'b1;
        step();

        // ---- write, accepted at cycle 1 ----
        av0 = n_av_cycles;
        setup(1'b1, 32'h40, 32'hDEADBEEF, 4'hF);
        step();                                 // cycle 1
        check("wr_avalid_c1", 32'(bus.iob_avalid_o), 32'd1);
        check("wr_addr",      bus.iob_addr_o,        32'h40);
        check("wr_wdata",     bus.iob_wdata_o,       32'hDEADBEEF);
        check("wr_wstrb",     32'(bus.iob_wstrb_o),  32'hF);
        check("wr_ready_c1",  32'(bus.apb_ready_o),  32'd0);
        bus.apb_enable_i = 1'b1;
        bus.iob_ready_i  = 1'b1;
        step();                                 // cycle 2
        check("wr_avalid_c2", 32'(bus.iob_avalid_o), 32'd0);
        check("wr_ready_c2",  32'(bus.apb_ready_o),  32'd1);
        check("wr_slverr",    32'(bus.apb_slverr_o), 32'd0);
        bus.iob_ready_i = 1'b0;
        idle_bus();
        step();                                 // cycle 3
        check("wr_ready_c3",  32'(bus.apb_ready_o),  32'd0);
        check("wr_wstrb_clr", 32'(bus.iob_wstrb_o),  32'd0);
        check("wr_av_cycles", 32'(n_av_cycles - av0), 32'd1);

        // ---- read, ready delayed 3 cycles, rvalid 2 cycles after acceptance ----
        setup(1'b0, 32'h80, 32'h0, 4'hF);
        step();                                 // cycle 1
        check("rd_avalid_c1", 32'(bus.iob_avalid_o), 32'd1);
        check("rd_wstrb",     32'(bus.iob_wstrb_o),  32'd0);
        check("rd_addr",      bus.iob_addr_o,        32'h80);
        bus.apb_enable_i = 1'b1;
        step();                                 // cycle 2
        step();                                 // cycle 3
        step();                                 // cycle 4
        check("rd_avalid_c4", 32'(bus.iob_avalid_o), 32'd1);
        bus.iob_ready_i = 1'b1;
        step();                                 // cycle 5
        bus.iob_ready_i = 1'b0;
        check("rd_avalid_c5", 32'(bus.iob_avalid_o), 32'd0);
        check("rd_ready_c5",  32'(bus.apb_ready_o),  32'd0);
        step();                                 // cycle 6
        bus.iob_rvalid_i = 1'b1;
        bus.iob_rdata_i  = 32'h12345678;
        step();                                 // cycle 7
        bus.iob_rvalid_i = 1'b0;
        bus.iob_rdata_i  = 32'h0;
        check("rd_ready_c7",  32'(bus.apb_ready_o),  32'd1);
        check("rd_rdata",     bus.apb_rdata_o,       32'h12345678);
        check("rd_slverr",    32'(bus.apb_slverr_o), 32'd0);
        idle_bus();
        step();                                 // cycle 8
        check("rd_ready_c8",  32'(bus.apb_ready_o),  32'd0);
        check("rd_rdata_hold", bus.apb_rdata_o,      32'h12345678);

        // ---- null write ----
        av0 = n_av_cycles;
        setup(1'b1, 32'h10, 32'h55555555, 4'h0);
        step();                                 // cycle 1
        check("nw_ready_c1",  32'(bus.apb_ready_o),  32'd1);
        check("nw_slverr",    32'(bus.apb_slverr_o), 32'd0);
        check("nw_avalid",    32'(bus.iob_avalid_o), 32'd0);
        bus.apb_enable_i = 1'b1;
        step();                                 // cycle 2
        idle_bus();
        check("nw_ready_c2",  32'(bus.apb_ready_o),  32'd0);
        step();
        check("nw_av_cycles", 32'(n_av_cycles - av0), 32'd0);
        check("nw_acc_count", 32'(acc_addr.size()), 32'd2);

        // ---- timeout: slave never readies, TIMEOUT = 8 ----
        av0 = n_av_cycles;
        setup(1'b0, 32'hC0, 32'h0, 4'h0);
        step();                                 // cycle 1
        bus.apb_enable_i = 1'b1;
        for (int i = 2; i <= 8; i++) step();    // cycles 2..8
        check("to_avalid_c8", 32'(bus.iob_avalid_o), 32'd1);
        step();                                 // cycle 9
        check("to_avalid_c9", 32'(bus.iob_avalid_o), 32'd0);
        check("to_ready",     32'(bus.apb_ready_o),  32'd1);
        check("to_slverr",    32'(bus.apb_slverr_o), 32'd1);
        check("to_rdata",     bus.apb_rdata_o,       32'd0);
        check("to_av_cycles", 32'(n_av_cycles - av0), 32'd8);
        idle_bus();
        bus.iob_ready_i  = 1'b1;                // late responses, must be ignored
        bus.iob_rvalid_i = 1'b1;
        bus.iob_rdata_i  = 32'hFFFFFFFF;
        step();
        check("late_ready",   32'(bus.apb_ready_o),  32'd0);
        check("late_slverr",  32'(bus.apb_slverr_o), 32'd0);
        step();
        check("late_avalid",  32'(bus.iob_avalid_o), 32'd0);
        check("late_rdata",   bus.apb_rdata_o,       32'd0);
        bus.iob_ready_i  = 1'b0;
        bus.iob_rvalid_i = 1'b0;
        bus.iob_rdata_i  = 32'h0;

        // ---- back-to-back write then read, slave always ready ----
        bus.iob_ready_i = 1'b1;
        setup(1'b1, 32'h44, 32'hA5A5A5A5, 4'h3);
        step();                                 // cycle 1
        check("bb_wr_avalid", 32'(bus.iob_avalid_o), 32'd1);
        bus.apb_enable_i = 1'b1;
        step();                                 // cycle 2
        check("bb_wr_ready",  32'(bus.apb_ready_o),  32'd1);
        step();                                 // cycle 3: next setup right after DONE
        setup(1'b0, 32'h48, 32'h0, 4'h0);
        step();                                 // cycle 4
        check("bb_rd_avalid", 32'(bus.iob_avalid_o), 32'd1);
        check("bb_rd_addr",   bus.iob_addr_o,        32'h48);
        bus.apb_enable_i = 1'b1;
        step();                                 // cycle 5
        bus.iob_ready_i  = 1'b0;
        bus.iob_rvalid_i = 1'b1;
        bus.iob_rdata_i  = 32'h0BADF00D;
        step();                                 // cycle 6
        bus.iob_rvalid_i = 1'b0;
        check("bb_rd_ready",  32'(bus.apb_ready_o),  32'd1);
        check("bb_rd_rdata",  bus.apb_rdata_o,       32'h0BADF00D);
        idle_bus();
        step();
        check("bb_acc_count", 32'(acc_addr.size()), 32'd4);
        if (acc_addr.size() >= 4) begin
            check("bb_acc_first",  acc_addr[2], 32'h44);
            check("bb_acc_second", acc_addr[3], 32'h48);
        end

        // ---- reset asserted while in RDWAIT ----
        setup(1'b0, 32'h20, 32'h0, 4'h0);
        step();                                 // cycle 1
        bus.apb_enable_i = 1'b1;
        bus.iob_ready_i  = 1'b1;
        step();                                 // cycle 2: RDWAIT
        bus.iob_ready_i = 1'b0;
        #2;
        arst_n = 1'b0;
        #1;
        check("ar_avalid", 32'(bus.iob_avalid_o), 32'd0);
        check("ar_ready",  32'(bus.apb_ready_o),  32'd0);
        check("ar_rdata",  bus.apb_rdata_o,       32'd0);
        check("ar_addr",   bus.iob_addr_o,        32'd0);
        idle_bus();
        step();
        arst_n = 1'b1;
        step();
        setup(1'b0, 32'h24, 32'h0, 4'h0);
        step();                                 // cycle 1
        check("ar_rd_avalid", 32'(bus.iob_avalid_o), 32'd1);
        bus.apb_enable_i = 1'b1;
        bus.iob_ready_i  = 1'b1;
        step();                                 // cycle 2
        bus.iob_ready_i  = 1'b0;
        bus.iob_rvalid_i = 1'b1;
        bus.iob_rdata_i  = 32'hCAFEF00D;
        step();                                 // cycle 3
        bus.iob_rvalid_i = 1'b0;
        check("ar_rd_ready", 32'(bus.apb_ready_o),  32'd1);
        check("ar_rd_rdata", bus.apb_rdata_o,       32'hCAFEF00D);
        check("ar_rd_err",   32'(bus.apb_slverr_o), 32'd0);
        idle_bus();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb2iob.md
Name: apb2iob

Overview:
- Bridges an APB slave interface to an IOb master interface.
- It is the counterpart of the IOb-to-APB bridge: an external APB master (e.g. a debug or host bus) drives system peripherals that expose IOb slave ports.
- Each APB transfer becomes exactly one IOb request.
- A cycle timeout guards against an unresponsive IOb slave and reports the failure as an APB slave error.

Parameters:
- APB_ADDR_W, 32, APB address width in bits.
- APB_DATA_W, 32, APB data width in bits; must be a multiple of 8.
- ADDR_W, APB_ADDR_W, IOb address width in bits.
- DATA_W, APB_DATA_W, IOb data width in bits.
- TIMEOUT, 256, maximum cycles spent waiting on the IOb side; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  asynchronous active-low reset
- cke_i  in  1  clock enable; when 0, all state holds
- apb_sel_i  in  1  APB select
- apb_enable_i  in  1  APB enable (access phase)
- apb_addr_i  in  APB_ADDR_W  APB address
- apb_write_i  in  1  1 = write, 0 = read
- apb_wstrb_i  in  DATA_W/8  APB byte strobes
- apb_wdata_i  in  DATA_W  APB write data
- apb_rdata_o  out  DATA_W  APB read data
- apb_ready_o  out  1  APB transfer complete
- apb_slverr_o  out  1  APB error, valid with apb_ready_o
- iob_avalid_o  out  1  IOb request valid
- iob_addr_o  out  ADDR_W  IOb address
- iob_wdata_o  out  DATA_W  IOb write data
- iob_wstrb_o  out  DATA_W/8  IOb strobes; 0 = read
- iob_rvalid_i  in  1  IOb read data valid
- iob_rdata_i  in  DATA_W  IOb read data
- iob_ready_i  in  1  IOb request accepted

Behaviour:
- Reset, clocking and outputs:
  - Every output is registered.
  - Reset value of all outputs is 0; FSM resets to IDLE and the timeout counter to 0.
  - cke_i=0 freezes all registers.
- FSM states: IDLE, REQ, RDWAIT, DONE.
- IDLE:
  - A setup phase (apb_sel_i=1, apb_enable_i=0, apb_ready_o=0) is sampled.
  - iob_addr_o is loaded from apb_addr_i[ADDR_W-1:0], iob_wdata_o from apb_wdata_i.
  - iob_wstrb_o is loaded from apb_write_i ? apb_wstrb_i : 0.
  - Write with apb_wstrb_i==0 (null write): no IOb request is issued; go to DONE with slverr=0.
  - Otherwise set iob_avalid_o=1, clear the counter, go to REQ.
- REQ:
  - iob_avalid_o and the address, data and strobe outputs are held stable until a cycle with iob_ready_i=1.
  - In that cycle the request is accepted and iob_avalid_o drops on the next edge.
  - Accepted write goes to DONE.
  - Accepted read goes to RDWAIT.
  - iob_rvalid_i is ignored in REQ.
- RDWAIT:
  - On iob_rvalid_i=1, apb_rdata_o is loaded with iob_rdata_i and the FSM goes to DONE.
  - iob_rvalid_i asserted in the same cycle as acceptance is not sampled; the IOb slave returns rvalid at least one cycle after acceptance.
- DONE:
  - apb_ready_o=1 for exactly one cycle, overlapping the master's access phase.
  - On the next edge apb_ready_o, apb_slverr_o and iob_wstrb_o clear and the FSM returns to IDLE.
  - apb_rdata_o holds its last value until the next read completes.
- Latency, counted in cycles with setup at cycle 0:
  - iob_avalid_o is high at cycle 1.
  - If iob_ready_i is 1 at cycle 1, a write shows apb_ready_o at cycle 2.
  - If iob_rvalid_i is 1 at cycle 2, a read shows apb_ready_o at cycle 3.
  - A null write shows apb_ready_o at cycle 1.
- Timeout:
  - The counter is clog2(TIMEOUT+1) bits wide and increments each cycle in REQ or RDWAIT.
  - On reaching TIMEOUT-1 without the awaited event, iob_avalid_o drops, apb_rdata_o is set to 0, apb_slverr_o=1, and the FSM goes to DONE.
  - A ready or rvalid arriving in the same cycle as the timeout wins: normal completion, no error.
  - Late rvalid or ready arriving after a timeout is ignored in IDLE.
  - With TIMEOUT=0 the bridge waits indefinitely.
- Master misbehaviour: if apb_sel_i drops mid-transfer, the IOb transaction still completes and the ready pulse is still issued; the bridge never issues a second IOb request for one APB transfer.
- Reset mid-operation: asserting arst_n_i=0 immediately clears all outputs, including iob_avalid_o, and returns the FSM to IDLE.

Test Plan:
- Write with addr=0x40, wdata=0xDEADBEEF, wstrb=0xF, iob_ready_i=1 at cycle 1 -> iob_avalid_o high exactly 1 cycle with those values; apb_ready_o=1 at cycle 2; slverr=0.
- Read with addr=0x80, iob_ready_i delayed 3 cycles, rvalid 2 cycles after acceptance with rdata=0x12345678 -> iob_wstrb_o=0; apb_rdata_o=0x12345678 when apb_ready_o=1, a single pulse.
- Null write (write=1, wstrb=0) -> iob_avalid_o never asserts; apb_ready_o=1 at cycle 1; slverr=0.
- TIMEOUT=8, IOb slave never readies -> iob_avalid_o drops after 8 cycles; apb_ready_o=1 with slverr=1 and rdata=0; a late iob_ready_i is ignored and the next transfer works normally.
- Back-to-back: write then read with setup immediately after DONE -> two distinct IOb requests in order, no lost or duplicated pulses.
- Reset asserted while in RDWAIT -> all outputs 0 asynchronously; after release, a new read completes correctly.
